// File: rtl/lock_code_entry.sv
`default_nettype none
// ============================================================================
// Module      : lock_code_entry
// Description : Keypad front end for the combination lock. Synchronises and
//               debounces a raw hex key and pairs two presses into one byte
//               (high nibble first). Each byte is presented on `code` for
//               exactly one cycle. Otherwise `code` holds IDLE_CODE.
//               An entry with only its high nibble is discarded after
//               TIMEOUT_CYCLES of inactivity.
// Ports       : clk           - clock
//               reset_n       - synchronous active-low reset
//               key_raw       - asynchronous raw key-pressed level (bouncy)
//               key_val       - asynchronous hex key value, stable while pressed
//               code          - assembled byte for one cycle, else IDLE_CODE
//               code_valid    - high in the cycle `code` carries a byte
//               busy          - high nibble held, low nibble awaited
//               timeout_pulse - one-cycle pulse when a partial entry is dropped
// Revision    : 1.0 - initial release
// ============================================================================
module lock_code_entry #(
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter int         TIMEOUT_CYCLES  = 1000,
  parameter logic [7:0] IDLE_CODE       = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_raw,
  input  logic [3:0] key_val,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       busy,
  output logic       timeout_pulse
);

  localparam int c_db_w = $clog2(DEBOUNCE_CYCLES);
  localparam int c_tm_w = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_tm_w-1:0] c_tm_last = c_tm_w'(TIMEOUT_CYCLES - 1);

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_high = 1'b1;

  // --------------------------------------------------------------------------
  // Two-flop synchronisers. key_val is stable for the whole time the key is
  // held, so a plain per-bit synchroniser gives a coherent value once the
  // debounced press appears.
  // --------------------------------------------------------------------------
  logic [1:0] r_key_sync;
  logic [3:0] r_val_meta;
  logic [3:0] r_val_s;
  logic       w_key_s;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_key_sync <= 2'b00;
      r_val_meta <= 4'h0;
      r_val_s    <= 4'h0;
    end else begin
      r_key_sync <= {r_key_sync[0], key_raw};
      r_val_meta <= key_val;
      r_val_s    <= r_val_meta;
    end
  end

  assign w_key_s = r_key_sync[1];

  // --------------------------------------------------------------------------
  // Debounce: the synchronised level must disagree with the accepted level
  // for DEBOUNCE_CYCLES consecutive cycles before it is taken.
  // --------------------------------------------------------------------------
  logic [c_db_w-1:0] r_db_cnt;
  logic              r_key_db;
  logic              r_key_db_q;
  logic              w_press;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_db_cnt   <= '0;
      r_key_db   <= 1'b0;
      r_key_db_q <= 1'b0;
    end else begin
      r_key_db_q <= r_key_db;
      if (w_key_s == r_key_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == c_db_last) begin
        r_key_db <= w_key_s;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + c_db_w'(1);
      end
    end
  end

  // One event per debounced rising edge, no matter how long the key is held.
  assign w_press = r_key_db & ~r_key_db_q;

  // --------------------------------------------------------------------------
  // Nibble-pairing FSM
  // --------------------------------------------------------------------------
  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [3:0]        r_hi;
  logic [3:0]        w_hi_nxt;
  logic [c_tm_w-1:0] r_timer;
  logic [c_tm_w-1:0] w_timer_nxt;
  logic              w_timer_done;
  logic [7:0]        w_code_nxt;
  logic              w_valid_nxt;
  logic              w_tmo_nxt;

  assign w_timer_done = (r_timer == c_tm_last);

  // State register, plus the registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= c_st_idle;
      r_hi          <= 4'h0;
      r_timer       <= '0;
      code          <= IDLE_CODE;
      code_valid    <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_hi          <= w_hi_nxt;
      r_timer       <= w_timer_nxt;
      code          <= w_code_nxt;
      code_valid    <= w_valid_nxt;
      timeout_pulse <= w_tmo_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_hi_nxt    = r_hi;
    w_timer_nxt = r_timer;
    case (r_state)
      c_st_idle: begin
        if (w_press) begin
          w_state_nxt = c_st_high;
          w_hi_nxt    = r_val_s;
          w_timer_nxt = '0;
        end
      end
      c_st_high: begin
        // A press on the terminal timer cycle still completes the byte.
        if (w_press || w_timer_done) begin
          w_state_nxt = c_st_idle;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + c_tm_w'(1);
        end
      end
      default: begin
        w_state_nxt = c_st_idle;
        w_timer_nxt = '0;
      end
    endcase
  end

  // Output logic: next values for the registered outputs, and busy.
  always_comb begin
    busy        = (r_state == c_st_high);
    w_code_nxt  = IDLE_CODE;
    w_valid_nxt = 1'b0;
    w_tmo_nxt   = 1'b0;
    if (r_state == c_st_high) begin
      if (w_press) begin
        w_code_nxt  = {r_hi, r_val_s};
        w_valid_nxt = 1'b1;
      end else if (w_timer_done) begin
        w_tmo_nxt = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lock_code_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_lock_code_entry
// Description : Bench for lock_code_entry with DEBOUNCE_CYCLES=4 and
//               TIMEOUT_CYCLES=50. A reference model predicts every output
//               each cycle. The model works from the keypad rules: the
//               synchronised key is the raw key two edges late. A level is
//               accepted after a window of differing samples. A partial
//               entry has a deadline.
//               Directed scenarios follow, then randomized bouncy presses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lock_code_entry;

  localparam int c_deb  = 4;
  localparam int c_tmo  = 50;
  localparam int c_ring = 64;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_raw = 1'b0;
  logic [3:0] key_val = 4'h0;
  logic [7:0] code;
  logic       code_valid;
  logic       busy;
  logic       timeout_pulse;

  always #5 clk = ~clk;

  lock_code_entry #(
    .DEBOUNCE_CYCLES(c_deb),
    .TIMEOUT_CYCLES (c_tmo),
    .IDLE_CODE      (8'h00)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .key_raw      (key_raw),
    .key_val      (key_val),
    .code         (code),
    .code_valid   (code_valid),
    .busy         (busy),
    .timeout_pulse(timeout_pulse)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         n      = 0;     // edge counter
  int         r_edge = -100;  // last edge sampled in reset
  logic       raw_h [c_ring];
  logic [3:0] val_h [c_ring];
  logic       db = 1'b0, db_prev = 1'b0, pend = 1'b0;
  logic [3:0] hi = 4'h0;
  int         start = 0;
  logic [7:0] m_code = 8'h00;
  logic       m_valid = 1'b0, m_busy = 1'b0, m_tmo = 1'b0;

  // Synchronised copies seen by the logic at edge idx: raw from two edges
  // earlier, forced low while the synchroniser was still clearing.
  function automatic logic ks_at(input int idx);
    if (idx - 2 <= r_edge) return 1'b0;
    return raw_h[(idx - 2) % c_ring];
  endfunction

  function automatic logic [3:0] vs_at(input int idx);
    if (idx - 2 <= r_edge) return 4'h0;
    return val_h[(idx - 2) % c_ring];
  endfunction

  task automatic model_edge();
    logic       press;
    logic       flip;
    logic [3:0] pv;
    n++;
    raw_h[n % c_ring] = key_raw;
    val_h[n % c_ring] = key_val;
    m_code  = 8'h00;
    m_valid = 1'b0;
    m_tmo   = 1'b0;
    if (!reset_n) begin
      r_edge  = n;
      db      = 1'b0;
      db_prev = 1'b0;
      pend    = 1'b0;
    end else begin
      press = db & ~db_prev;
      pv    = vs_at(n);
      flip  = 1'b1;
      for (int k = 0; k < c_deb; k++) begin
        if (ks_at(n - k) == db) flip = 1'b0;
      end
      db_prev = db;
      if (flip) db = ~db;
      if (pend) begin
        if (press) begin
          m_valid = 1'b1;
          m_code  = {hi, pv};
          pend    = 1'b0;
        end else if (n - start == c_tmo) begin
          m_tmo = 1'b1;
          pend  = 1'b0;
        end
      end else if (press) begin
        pend  = 1'b1;
        hi    = pv;
        start = n;
      end
    end
    m_busy = pend;
  endtask

  // ---------------- observation counters ----------------
  int         obs_valid = 0;
  int         obs_tmo   = 0;
  int         obs_busy  = 0;
  logic [7:0] obs_codes[$];

  task automatic clear_obs();
    obs_valid = 0;
    obs_tmo   = 0;
    obs_busy  = 0;
    obs_codes.delete();
  endtask

  // One clock: drive at the falling edge, model at the rising edge, compare
  // at the next falling edge.
  task automatic tick(input logic k, input logic [3:0] v);
    key_raw = k;
    key_val = v;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("code", {24'h0, code}, {24'h0, m_code});
    check_eq("code_valid", {31'h0, code_valid}, {31'h0, m_valid});
    check_eq("busy", {31'h0, busy}, {31'h0, m_busy});
    check_eq("timeout_pulse", {31'h0, timeout_pulse}, {31'h0, m_tmo});
    if (code_valid === 1'b1) begin
      obs_valid++;
      obs_codes.push_back(code);
    end
    if (timeout_pulse === 1'b1) obs_tmo++;
    if (busy === 1'b1) obs_busy++;
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    repeat (cycles) tick(1'b0, 4'h0);
    reset_n = 1'b1;
  endtask

  task automatic press_key(input logic [3:0] v);
    repeat (8) tick(1'b1, v);
    repeat (8) tick(1'b0, v);
  endtask

  initial begin
    logic [3:0] v;
    logic [3:0] v2;
    int         r;

    @(negedge clk);
    do_reset(3);
    check_eq("rst_code", {24'h0, code}, 32'h00);
    check_eq("rst_valid", {31'h0, code_valid}, 32'h0);
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_tmo", {31'h0, timeout_pulse}, 32'h0);
    repeat (5) tick(1'b0, 4'h0);

    // Clean A, A.
    clear_obs();
    press_key(4'hA);
    press_key(4'hA);
    check_eq("aa_count", obs_valid, 1);
    check_eq("aa_byte", {24'h0, obs_codes[0]}, 32'hAA);

    // A,A,B,B,C,C.
    clear_obs();
    press_key(4'hA); press_key(4'hA);
    press_key(4'hB); press_key(4'hB);
    press_key(4'hC); press_key(4'hC);
    check_eq("seq_count", obs_valid, 3);
    check_eq("seq_b0", {24'h0, obs_codes[0]}, 32'hAA);
    check_eq("seq_b1", {24'h0, obs_codes[1]}, 32'hBB);
    check_eq("seq_b2", {24'h0, obs_codes[2]}, 32'hCC);

    // Short glitches never register.
    clear_obs();
    repeat (10) begin
      repeat (2) tick(1'b1, 4'h5);
      repeat (3) tick(1'b0, 4'h5);
    end
    repeat (10) tick(1'b0, 4'h5);
    check_eq("glitch_valid", obs_valid, 0);
    check_eq("glitch_busy", obs_busy, 0);

    // Long hold: one nibble, which then times out.
    clear_obs();
    repeat (200) tick(1'b1, 4'h6);
    repeat (10) tick(1'b0, 4'h6);
    check_eq("hold_valid", obs_valid, 0);
    check_eq("hold_tmo", obs_tmo, 1);

    // Timeout, then a clean B,B.
    clear_obs();
    press_key(4'h3);
    repeat (c_tmo) tick(1'b0, 4'h3);
    check_eq("tmo_count", obs_tmo, 1);
    check_eq("tmo_busy", {31'h0, busy}, 32'h0);
    press_key(4'hB);
    press_key(4'hB);
    check_eq("tmo_bb_count", obs_valid, 1);
    check_eq("tmo_bb_byte", {24'h0, obs_codes[0]}, 32'hBB);

    // Reset mid-entry.
    clear_obs();
    press_key(4'h7);
    do_reset(1);
    check_eq("mid_rst_busy", {31'h0, busy}, 32'h0);
    check_eq("mid_rst_code", {24'h0, code}, 32'h00);
    check_eq("mid_rst_valid", {31'h0, code_valid}, 32'h0);
    press_key(4'h1);
    press_key(4'h2);
    check_eq("rst_12_count", obs_valid, 1);
    check_eq("rst_12_byte", {24'h0, obs_codes[0]}, 32'h12);

    // Second press landing one edge before, and exactly on, the timeout edge.
    for (int off = -1; off <= 0; off++) begin
      clear_obs();
      v  = 4'h9 + 4'(off);
      v2 = 4'h4;
      press_key(v);
      // A clean rise sampled at edge e yields its press event at edge e+6.
      while (n + 1 < start + c_tmo - 6 + off) tick(1'b0, v);
      press_key(v2);
      check_eq("edge_count", obs_valid, 1);
      check_eq("edge_byte", {24'h0, obs_codes[0]}, {24'h0, v, v2});
      check_eq("edge_tmo", obs_tmo, 0);
    end

    // One edge too late: timeout first, the late press opens a new entry.
    clear_obs();
    press_key(4'hE);
    while (n + 1 < start + c_tmo - 5) tick(1'b0, 4'hE);
    press_key(4'hD);
    repeat (c_tmo + 5) tick(1'b0, 4'hD);
    check_eq("late_valid", obs_valid, 0);
    check_eq("late_tmo", obs_tmo, 2);

    // Randomized bouncy traffic.
    for (int i = 0; i < 200; i++) begin
      v = 4'($urandom_range(0, 15));
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        do_reset(1 + int'($urandom_range(0, 2)));
      end else if (r < 20) begin
        repeat ($urandom_range(1, c_deb - 1)) tick(1'b1, v);
        repeat ($urandom_range(c_deb, 6)) tick(1'b0, v);
      end else begin
        repeat ($urandom_range(0, 3)) begin
          tick(1'b1, v);
          tick(1'b0, v);
        end
        repeat ($urandom_range(c_deb + 2, 20)) tick(1'b1, v);
        repeat ($urandom_range(0, 2)) begin
          tick(1'b0, v);
          tick(1'b1, v);
        end
        repeat ($urandom_range(c_deb + 2, 20)) tick(1'b0, v);
        if ($urandom_range(0, 9) == 0) repeat (c_tmo) tick(1'b0, v);
      end
    end
    repeat (c_tmo + 10) tick(1'b0, 4'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
